// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the 5-stage MIPS EX stage.
//   - ALU opcode constants (ALU_ADD .. ALU_LINK)
//   - operand A/B source-select encodings
//   - forwarding-select encoding used by ex_forward_unit
//   - ALU_NOP: opcode driven for a pipeline bubble
package mips_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_LUI  = 4'b1011;
  localparam logic [3:0] ALU_LINK = 4'b1100;

  // A bubble executes as an add of zeros with no side effects.
  localparam logic [3:0] ALU_NOP  = ALU_ADD;

  // Operand A sources.
  localparam logic [1:0] ASEL_RS    = 2'd0;
  localparam logic [1:0] ASEL_SHAMT = 2'd1;
  localparam logic [1:0] ASEL_ZERO  = 2'd2;

  // Operand B sources.
  localparam logic [1:0] BSEL_RT  = 2'd0;
  localparam logic [1:0] BSEL_IMM = 2'd1;
  localparam logic [1:0] BSEL_PC  = 2'd2;

  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/ex_forward_unit.sv
// ex_forward_unit: resolves one EX source operand against MEM and WB writers.
// Ports:
//   src_addr_i            source register index held in EX
//   reg_data_i            register-file value captured in ID
//   mem_reg_write_i/mem_rd_addr_i/mem_result_i   MEM-stage writer
//   wb_reg_write_i/wb_rd_addr_i/wb_result_i      WB-stage writer
//   fwd_data_o            freshest value of the source
//   fwd_sel_o             which source supplied fwd_data_o
module ex_forward_unit
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_addr_i,
  input  logic [DATA_W-1:0]     reg_data_i,
  input  logic                  mem_reg_write_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr_i,
  input  logic [DATA_W-1:0]     mem_result_i,
  input  logic                  wb_reg_write_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr_i,
  input  logic [DATA_W-1:0]     wb_result_i,
  output logic [DATA_W-1:0]     fwd_data_o,
  output fwd_sel_e              fwd_sel_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    fwd_sel_o  = FWD_REG;
    fwd_data_o = reg_data_i;
    // $zero is hard-wired, so a "write" to it must never shadow the register value.
    // MEM is younger than WB, hence checked first.
    if (src_addr_i != '0) begin
      if (mem_reg_write_i && (mem_rd_addr_i == src_addr_i)) begin
        fwd_sel_o  = FWD_MEM;
        fwd_data_o = mem_result_i;
      end else if (wb_reg_write_i && (wb_rd_addr_i == src_addr_i)) begin
        fwd_sel_o  = FWD_WB;
        fwd_data_o = wb_result_i;
      end
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register, MEM/WB forwarding, ALU operand
// selection and load-use hazard detection.
// Inputs : id_* decoded fields, mem_*/wb_* forwarding writers, flush, stall_in.
// Outputs: ex_* EX-slot contents and ALU operands, hazard_stall to the front end.
// Optional: define HAZARD_PERF_EN to add perf_load_use_cnt / perf_flush_cnt,
// saturating 32-bit cycle counters of hazard_stall and flush.
module id_ex_operand_stage
  import mips_pkg::*;
#(
  parameter int                    DATA_W       = 32,
  parameter int                    REG_ADDR_W   = 5,
  parameter int                    ALU_CTRL_W   = 4,
  parameter logic [ALU_CTRL_W-1:0] NOP_ALU_CTRL = 4'b0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [4:0]            id_shamt,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [ALU_CTRL_W-1:0] id_alu_control,
  input  logic [1:0]            id_a_sel,
  input  logic [1:0]            id_b_sel,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0]     mem_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0]     wb_result,
  input  logic                  flush,
  input  logic                  stall_in,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_operand_A,
  output logic [DATA_W-1:0]     ex_operand_B,
  output logic [ALU_CTRL_W-1:0] ex_alu_control,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
`ifdef HAZARD_PERF_EN
  output logic [31:0]           perf_load_use_cnt,
  output logic [31:0]           perf_flush_cnt,
`endif
  output logic                  hazard_stall
);

  typedef struct packed {
    logic                  valid;
    logic [DATA_W-1:0]     rs_data;
    logic [DATA_W-1:0]     rt_data;
    logic [REG_ADDR_W-1:0] rs_addr;
    logic [REG_ADDR_W-1:0] rt_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0]     imm;
    logic [4:0]            shamt;
    logic [DATA_W-1:0]     pc;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [1:0]            a_sel;
    logic [1:0]            b_sel;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
  } ex_slot_t;

  ex_slot_t            slot_q, slot_d, bubble;
  logic [DATA_W-1:0]   fwd_rs_data, fwd_rt_data;
  fwd_sel_e            fwd_rs_sel, fwd_rt_sel;
  logic                load_use;

  ex_forward_unit #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .src_addr_i      (slot_q.rs_addr),
    .reg_data_i      (slot_q.rs_data),
    .mem_reg_write_i (mem_reg_write),
    .mem_rd_addr_i   (mem_rd_addr),
    .mem_result_i    (mem_result),
    .wb_reg_write_i  (wb_reg_write),
    .wb_rd_addr_i    (wb_rd_addr),
    .wb_result_i     (wb_result),
    .fwd_data_o      (fwd_rs_data),
    .fwd_sel_o       (fwd_rs_sel)
  );

  ex_forward_unit #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .src_addr_i      (slot_q.rt_addr),
    .reg_data_i      (slot_q.rt_data),
    .mem_reg_write_i (mem_reg_write),
    .mem_rd_addr_i   (mem_rd_addr),
    .mem_result_i    (mem_result),
    .wb_reg_write_i  (wb_reg_write),
    .wb_rd_addr_i    (wb_rd_addr),
    .wb_result_i     (wb_result),
    .fwd_data_o      (fwd_rt_data),
    .fwd_sel_o       (fwd_rt_sel)
  );

  // Load-use: the consumer in ID needs a value the load in EX has not fetched yet.
  // Suppressed while the slot is held or squashed, since no new capture happens.
  always_comb begin
    load_use = slot_q.valid && slot_q.mem_read && (slot_q.rd_addr != '0) && id_valid &&
               ((id_rs_used && (id_rs_addr == slot_q.rd_addr)) ||
                (id_rt_used && (id_rt_addr == slot_q.rd_addr)));
    hazard_stall = load_use && !stall_in && !flush;
  end

  always_comb begin
    bubble          = '0;
    bubble.alu_ctrl = NOP_ALU_CTRL;
    slot_d          = slot_q;
    if (flush) begin
      slot_d = bubble;
    end else if (stall_in) begin
      // Absorb any value retiring from WB while frozen; once that writer leaves,
      // the stored copy is the only place the result still lives.
      if (fwd_rs_sel != FWD_REG) slot_d.rs_data = fwd_rs_data;
      if (fwd_rt_sel != FWD_REG) slot_d.rt_data = fwd_rt_data;
    end else if (hazard_stall) begin
      slot_d = bubble;
    end else begin
      slot_d.valid     = id_valid;
      slot_d.rs_data   = id_rs_data;
      slot_d.rt_data   = id_rt_data;
      slot_d.rs_addr   = id_rs_addr;
      slot_d.rt_addr   = id_rt_addr;
      slot_d.rd_addr   = id_rd_addr;
      slot_d.imm       = id_imm;
      slot_d.shamt     = id_shamt;
      slot_d.pc        = id_pc;
      slot_d.alu_ctrl  = id_alu_control;
      slot_d.a_sel     = id_a_sel;
      slot_d.b_sel     = id_b_sel;
      slot_d.reg_write = id_reg_write;
      slot_d.mem_read  = id_mem_read;
      slot_d.mem_write = id_mem_write;
    end
  end

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous, so rst_n is only examined on the clock edge.
    if (!rst_n) slot_q <= bubble;
    else        slot_q <= slot_d;
  end

  always_comb begin
    ex_operand_A = '0;
    ex_operand_B = '0;
    case (slot_q.a_sel)
      ASEL_RS:    ex_operand_A = fwd_rs_data;
      ASEL_SHAMT: ex_operand_A = {{(DATA_W-5){1'b0}}, slot_q.shamt};
      default:    ex_operand_A = '0;
    endcase
    case (slot_q.b_sel)
      BSEL_RT:  ex_operand_B = fwd_rt_data;
      BSEL_IMM: ex_operand_B = slot_q.imm;
      BSEL_PC:  ex_operand_B = slot_q.pc;
      default:  ex_operand_B = '0;
    endcase
  end

  assign ex_valid       = slot_q.valid;
  assign ex_alu_control = slot_q.alu_ctrl;
  assign ex_store_data  = fwd_rt_data;
  assign ex_rd_addr     = slot_q.rd_addr;
  assign ex_reg_write   = slot_q.reg_write & slot_q.valid;
  assign ex_mem_read    = slot_q.mem_read  & slot_q.valid;
  assign ex_mem_write   = slot_q.mem_write & slot_q.valid;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_load_use_cnt <= '0;
      perf_flush_cnt    <= '0;
    end else begin
      if (hazard_stall && (perf_load_use_cnt != '1)) perf_load_use_cnt <= perf_load_use_cnt + 32'd1;
      if (flush && (perf_flush_cnt != '1))           perf_flush_cnt    <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register plus EX-side operand selection for the 5-stage MIPS core.
- Captures decoded ID fields on each clock and resolves RAW hazards by forwarding from MEM and WB.
- Drives operand_A, operand_B and alu_control straight into the ALU.
- Detects load-use hazards, requests a one-cycle front-end stall, and inserts a bubble.

Parameters:
- DATA_W, 32, datapath width.
- REG_ADDR_W, 5, register-file address width.
- ALU_CTRL_W, 4, ALU opcode width.
- NOP_ALU_CTRL, 4'b0000, alu_control value driven for a bubble (add).

Ports:
- clk in 1: rising-edge clock.
- rst_n in 1: synchronous active-low reset.
- id_valid in 1: ID instruction valid.
- id_rs_data in DATA_W: register-file read data, rs.
- id_rt_data in DATA_W: register-file read data, rt.
- id_rs_addr in REG_ADDR_W: rs index.
- id_rt_addr in REG_ADDR_W: rt index.
- id_rd_addr in REG_ADDR_W: destination index (already muxed rd/rt/31).
- id_rs_used in 1: instruction reads rs.
- id_rt_used in 1: instruction reads rt.
- id_imm in DATA_W: extended immediate.
- id_shamt in 5: shift amount field.
- id_pc in DATA_W: instruction PC.
- id_alu_control in ALU_CTRL_W: ALU opcode.
- id_a_sel in 2: operand A source; 0=rs, 1=shamt zero-extended, 2=zero.
- id_b_sel in 2: operand B source; 0=rt, 1=imm, 2=pc.
- id_reg_write in 1: instruction writes a register.
- id_mem_read in 1: instruction is a load.
- id_mem_write in 1: instruction is a store.
- mem_reg_write in 1: MEM stage writes a register.
- mem_rd_addr in REG_ADDR_W: MEM destination index.
- mem_result in DATA_W: MEM forwarding value.
- wb_reg_write in 1: WB stage writes a register.
- wb_rd_addr in REG_ADDR_W: WB destination index.
- wb_result in DATA_W: WB forwarding value.
- flush in 1: squash the instruction entering EX.
- stall_in in 1: downstream hold; EX contents frozen.
- ex_valid out 1: EX slot holds a real instruction.
- ex_operand_A out DATA_W: to ALU operand_A.
- ex_operand_B out DATA_W: to ALU operand_B.
- ex_alu_control out ALU_CTRL_W: to ALU alu_control.
- ex_store_data out DATA_W: forwarded rt for stores.
- ex_rd_addr out REG_ADDR_W: EX destination index.
- ex_reg_write out 1: EX writes a register (gated by valid).
- ex_mem_read out 1: EX is a load (gated by valid).
- ex_mem_write out 1: EX is a store (gated by valid).
- hazard_stall out 1: hold PC and IF/ID.

Behaviour:
- Reset (rst_n=0 at posedge):
  - ex_valid=0; all stored fields 0; stored alu_control=NOP_ALU_CTRL.
  - Hence ex_reg_write/ex_mem_read/ex_mem_write=0, ex_operand_A/B=0, ex_store_data=0.
  - Reset overrides all other inputs.
- Update priority at posedge: reset > flush > stall_in > hazard_stall > load.
  - flush: bubble (valid=0, control bits 0, alu_control=NOP_ALU_CTRL), even while stall_in=1.
  - stall_in=1 (no flush): hold every field. Refresh stored rs/rt data with their forwarded values, so WB data retiring during the hold is not lost.
  - hazard_stall=1: load a bubble.
  - Otherwise load the ID fields; valid=id_valid.
- Latency: ID fields appear at EX outputs one cycle after capture. Forwarding and operand muxing are combinational from the stored fields.
- Forwarding, per source (rs, rt):
  - If MEM writes, mem_rd_addr equals the source index, and the index is non-zero: use mem_result.
  - Else if the same holds for WB: use wb_result.
  - Else use the stored data.
  - Register 0 is never forwarded. MEM has priority over WB when both match.
- Operand mux:
  - A = forwarded rs, {27'b0, shamt}, or 0, per a_sel.
  - B = forwarded rt, imm, or pc, per b_sel.
  - sel=3 is illegal; drive 0.
  - ex_store_data is always forwarded rt.
- Load-use (combinational):
  - hazard_stall = ex_valid & ex_mem_read & ex_rd_addr!=0 & id_valid & ((id_rs_used & id_rs_addr==ex_rd_addr) | (id_rt_used & id_rt_addr==ex_rd_addr)).
  - hazard_stall is forced 0 while stall_in or flush is asserted.
  - Asserts for exactly one cycle per load-use pair; the bubble removes the match on the next cycle.
- Control outputs ex_reg_write/ex_mem_read/ex_mem_write are the stored bits ANDed with ex_valid.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined:
  - Adds outputs perf_load_use_cnt (32) and perf_flush_cnt (32).
  - Counters increment on each cycle with hazard_stall=1 or flush=1, respectively.
  - Both saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package mips_pkg holds:
  - ALU opcode constants (ALU_ADD=0 through ALU_LINK=4'b1100).
  - a_sel/b_sel encodings.
  - Forward-select encoding (FWD_REG, FWD_MEM, FWD_WB).
  - NOP constant.
- Sub-module ex_forward_unit: one source index plus MEM/WB write ports in; forwarded data and select out. Instantiated twice (rs, rt).

Test Plan:
1. Reset: hold rst_n=0 two cycles with random inputs -> ex_valid=0, ex_operand_A=ex_operand_B=0, ex_alu_control=0, hazard_stall=0.
2. MEM/WB forwarding: EX rs=5, mem_rd=5 (mem_result=0x11), wb_rd=5 (wb_result=0x22), a_sel=0 -> ex_operand_A=0x11. Drop mem_reg_write -> 0x22. Set rs=0 with matches -> stored data.
3. Load-use: EX holds lw $8 and ID reads rt=8 with rt_used=1 -> hazard_stall=1 for one cycle, next EX ex_valid=0, alu_control=0; following cycle the consumer enters EX.
4. Flush beats stall: flush=1 with stall_in=1 -> next cycle ex_valid=0, ex_reg_write=0.
5. Hold with WB retire: stall_in=1 for 2 cycles; WB forwards 0xABCD to rt in cycle 1 only -> ex_operand_B=0xABCD in cycle 2 and after release.
6. Link op: b_sel=2, id_pc=0x00400010, alu_control=4'b1100 -> ex_operand_B=0x00400010 one cycle later; with HAZARD_PERF_EN, three flush pulses -> perf_flush_cnt=3.
